add_serial_param: RTL and testbench
===================================

# add_serial_param

Parametrised bit-serial adder/subtractor, the next generation of the team's 1-bit `add_serial` datapath. Operands of `WIDTH` bits are consumed `DIGIT` bits per cycle, LSB digit first. The block supports add and two's-complement subtract, and reports carry-out and signed overflow. It sits behind a simple start/done handshake in arithmetic datapaths where area matters more than latency.

## Interface
- `WIDTH`, default 8: operand and result width; must be a multiple of `DIGIT`.
- `DIGIT`, default 1: bits processed per cycle, from 1 to `WIDTH`.
- Derived: `N = WIDTH/DIGIT` digit cycles. `count` width is `max(1, $clog2(N))`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `en` input 1: start request; sampled only in IDLE and DONE.
- `sub` input 1: 0 selects a+b, 1 selects a-b; sampled with `en`.
- `a` input `WIDTH`: operand A; sampled with `en`.
- `b` input `WIDTH`: operand B; sampled with `en`.
- `out` output `WIDTH`: result register, valid while `done`=1.
- `cout` output 1: final carry out; for subtract, 1 means no borrow.
- `ovf` output 1: signed overflow of the result.
- `busy` output 1: high in ADD.
- `done` output 1: high in DONE.

## Operation
- States: IDLE, ADD, DONE. Reset state is IDLE.
- Reset (`rst`=0) forces: state IDLE, `out`=0, `cout`=0, `ovf`=0, `a_reg`=0, `b_reg`=0, `carry`=0, `count`=0. Reset takes effect immediately, including mid-operation, and any partial result is discarded.
- IDLE:
  - `en`=1 loads `a_reg`=`a` and `b_reg`=(`sub` ? ~`b` : `b`).
  - The same load sets `carry`=`sub`, `out`=0 and `count`=0, and captures `a_msb`=`a[WIDTH-1]` and `b_msb`=`b_reg` MSB after inversion.
  - State then goes to ADD. If `en`=0, the block holds.
- ADD, each cycle:
  - `{c, s}` = `a_reg[DIGIT-1:0]` + `b_reg[DIGIT-1:0]` + `carry`, computed as a (`DIGIT`+1)-bit sum.
  - `out` <= `{s, out[WIDTH-1:DIGIT]}`, filling MSB-first by shifting right.
  - `a_reg` and `b_reg` shift right by `DIGIT`; `carry` <= `c`; `count` <= `count`+1.
  - `en` is ignored in ADD.
- ADD exit: when `count`==N-1, the final digit is processed that cycle, then:
  - `cout` <= `c`.
  - `ovf` <= `a_msb` ^ `b_msb` ^ `s[DIGIT-1]` ^ `c`.
  - State goes to DONE.
- DONE:
  - `out`, `cout` and `ovf` hold.
  - `en`=1 performs the same load as IDLE and goes directly to ADD (back-to-back operation).
  - `en`=0 stays in DONE. There is no return to IDLE except by reset.
- Arithmetic wraps modulo 2^`WIDTH`. `cout` and `ovf` are the only indication of wrap.
- `DIGIT`=`WIDTH` special case: N=1, so a single ADD cycle.

## Timing
- Start: `en` high at edge k (state IDLE or DONE) puts the block in ADD from cycle k+1.
- Busy period: `busy`=1 for exactly N cycles.
- Completion: `done`=1 from edge k+N+1 onward, with `out`, `cout` and `ovf` valid the same cycle.
- Latency from start to result is therefore N+1 edges.
- `done` and `busy` are never high together.
- Flag timing: `cout` and `ovf` update only on the ADD-to-DONE edge.
- Flags during an operation:
  - On reload they keep their old value until the next completion.
  - `out` clears to 0 on load.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `add_serial_pkg` holds:
  - The state typedef: 2-bit enum with IDLE=0, ADD=1, DONE=2. Encoding 3 is illegal and recovers to IDLE.
  - The N/count-width helper function.
- Sub-module `digit_adder #(DIGIT)`: combinational `DIGIT`-bit ripple adder with carry in and out, instantiated once.
- Top level contains the FSM, shift registers and counter.

## Test plan
- WIDTH=8, DIGIT=1: `a`=3, `b`=5, `sub`=0 -> after 8 busy cycles, `done`=1, `out`=0x08, `cout`=0, `ovf`=0.
- WIDTH=8, DIGIT=1: `a`=200, `b`=100 -> `out`=0x2C, `cout`=1, `ovf`=0; then `a`=127, `b`=1 -> `out`=0x80, `cout`=0, `ovf`=1.
- WIDTH=8, DIGIT=2, `sub`=1: `a`=5, `b`=7 -> after 4 cycles, `out`=0xFE, `cout`=0, `ovf`=0. Then `a`=0x80, `b`=1 -> `out`=0x7F, `cout`=1, `ovf`=1.
- WIDTH=16, DIGIT=4: `a`=0xFFFF, `b`=1 -> `busy` for exactly 4 cycles, `out`=0x0000, `cout`=1. With DIGIT=16: one busy cycle, same result.
- Mid-operation events: toggle `en` during ADD -> no effect on result or cycle count. Assert `rst` low in cycle 3 of ADD -> all outputs 0, state IDLE immediately; the next `en` runs a clean operation.
- Back-to-back restart: in DONE, assert `en` with new operands -> next cycle `busy`=1, `out`=0, old `cout`/`ovf` held until the new completion, and the new result is correct.

Source files
------------

// File: rtl/add_serial_param_pkg.sv
// Shared types and sizing helpers for the parametrised bit-serial adder.
//   state_t    : FSM encoding (IDLE=0, ADD=1, DONE=2; 3 is illegal -> IDLE)
//   num_digits : number of digit cycles N = WIDTH/DIGIT
//   cnt_width  : digit counter width, max(1, clog2(N))
package add_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic int cnt_width(input int width, input int digit);
    int n;
    n = width / digit;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/add_serial_param_if.sv
// Start/done handshake bundle for add_serial_param.
//   master : drives en/sub/a/b, observes out/cout/ovf/busy/done
//   slave  : the adder side
interface add_serial_param_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output en, sub, a, b,
    input  out, cout, ovf, busy, done
  );

  modport slave (
    input  en, sub, a, b,
    output out, cout, ovf, busy, done
  );
endinterface

// File: rtl/add_serial_param_digit_adder.sv
// digit_adder: combinational DIGIT-bit ripple-carry adder.
//   x, y : addend digits
//   ci   : carry in
//   s    : sum digit
//   co   : carry out of the top bit
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);
  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co = c[DIGIT];
endmodule

// File: rtl/add_serial_param.sv
// add_serial_param: bit-serial adder/subtractor, DIGIT bits per cycle,
// LSB digit first. Subtract is a + ~b + 1 with the +1 injected as the
// initial carry.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : slave side of the handshake (en/sub/a/b in; out/cout/ovf/busy/done out)
module add_serial_param
  import add_serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic                clk,
  input  logic                rst,
  add_serial_param_if.slave   bus
);
  localparam int N  = num_digits(WIDTH, DIGIT);
  localparam int CW = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg, out_reg;
  logic [WIDTH-1:0] a_shf, b_shf, out_shf, b_load;
  logic [CW-1:0]    count;
  logic             carry, cout_reg, ovf_reg, a_msb, b_msb;
  logic [DIGIT-1:0] s;
  logic             c;
  logic             load, last;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x  (a_reg[DIGIT-1:0]),
    .y  (b_reg[DIGIT-1:0]),
    .ci (carry),
    .s  (s),
    .co (c)
  );

  // Single-digit configuration has nothing left to shift in.
  if (DIGIT == WIDTH) begin : g_one
    assign a_shf   = '0;
    assign b_shf   = '0;
    assign out_shf = s;
  end else begin : g_multi
    assign a_shf   = {{DIGIT{1'b0}}, a_reg[WIDTH-1:DIGIT]};
    assign b_shf   = {{DIGIT{1'b0}}, b_reg[WIDTH-1:DIGIT]};
    assign out_shf = {s, out_reg[WIDTH-1:DIGIT]};
  end

  assign b_load = bus.sub ? ~bus.b : bus.b;
  assign load   = ((state == IDLE) || (state == DONE)) && bus.en;
  assign last   = (state == ADD) && (count == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.en) state_nxt = ADD;
      ADD:     if (count == LAST) state_nxt = DONE;
      DONE:    if (bus.en) state_nxt = ADD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      out_reg  <= '0;
      count    <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
    end else if (load) begin
      a_reg   <= bus.a;
      b_reg   <= b_load;
      carry   <= bus.sub;
      out_reg <= '0;
      count   <= '0;
      a_msb   <= bus.a[WIDTH-1];
      b_msb   <= b_load[WIDTH-1];
    end else if (state == ADD) begin
      a_reg   <= a_shf;
      b_reg   <= b_shf;
      out_reg <= out_shf;
      carry   <= c;
      count   <= count + CW'(1);
      if (last) begin
        cout_reg <= c;
        // Carry into the MSB is a^b^s there; overflow is that xor carry out.
        ovf_reg  <= a_msb ^ b_msb ^ s[DIGIT-1] ^ c;
      end
    end
  end

  assign bus.out  = out_reg;
  assign bus.cout = cout_reg;
  assign bus.ovf  = ovf_reg;
  assign bus.busy = (state == ADD);
  assign bus.done = (state == DONE);
endmodule

// File: tb/tb_add_serial_param.sv
module tb_add_serial_param;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  add_serial_param_if #(.WIDTH(8))  if0 ();
  add_serial_param_if #(.WIDTH(8))  if1 ();
  add_serial_param_if #(.WIDTH(16)) if2 ();
  add_serial_param_if #(.WIDTH(16)) if3 ();

  add_serial_param #(.WIDTH(8),  .DIGIT(1))  u0 (.clk(clk), .rst(rst), .bus(if0));
  add_serial_param #(.WIDTH(8),  .DIGIT(2))  u1 (.clk(clk), .rst(rst), .bus(if1));
  add_serial_param #(.WIDTH(16), .DIGIT(4))  u2 (.clk(clk), .rst(rst), .bus(if2));
  add_serial_param #(.WIDTH(16), .DIGIT(16)) u3 (.clk(clk), .rst(rst), .bus(if3));

  int total = 0;
  int bad   = 0;
  bit prev_cout [4];
  bit prev_ovf  [4];

  function automatic int wid(input int w);
    return (w < 2) ? 8 : 16;
  endfunction

  function automatic int ndig(input int w);
    case (w)
      0:       return 8;
      1:       return 4;
      2:       return 4;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic en, input logic sub,
                       input logic [15:0] a, input logic [15:0] b);
    case (w)
      0: begin if0.en = en; if0.sub = sub; if0.a = a[7:0]; if0.b = b[7:0]; end
      1: begin if1.en = en; if1.sub = sub; if1.a = a[7:0]; if1.b = b[7:0]; end
      2: begin if2.en = en; if2.sub = sub; if2.a = a;      if2.b = b;      end
      default: begin if3.en = en; if3.sub = sub; if3.a = a; if3.b = b; end
    endcase
  endtask

  task automatic look(input int w, output logic [15:0] o, output logic co,
                      output logic ov, output logic bz, output logic dn);
    case (w)
      0: begin o = {8'h00, if0.out}; co = if0.cout; ov = if0.ovf; bz = if0.busy; dn = if0.done; end
      1: begin o = {8'h00, if1.out}; co = if1.cout; ov = if1.ovf; bz = if1.busy; dn = if1.done; end
      2: begin o = if2.out; co = if2.cout; ov = if2.ovf; bz = if2.busy; dn = if2.done; end
      default: begin o = if3.out; co = if3.cout; ov = if3.ovf; bz = if3.busy; dn = if3.done; end
    endcase
  endtask

  // Reference: integer add/subtract, unsigned carry/borrow and signed range check.
  task automatic model(input int width, input logic sub, input logic [15:0] a,
                       input logic [15:0] b, output logic [15:0] r,
                       output logic co, output logic ov);
    longint m, ua, ub, sa, sb, res, sres;
    m  = longint'(1) << width;
    ua = longint'(a) & (m - 1);
    ub = longint'(b) & (m - 1);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (!sub) begin
      res  = ua + ub;
      co   = (res >= m);
      sres = sa + sb;
    end else begin
      res  = ua - ub;
      co   = (ua >= ub);
      sres = sa - sb;
    end
    ov = (sres >= m / 2) || (sres < -(m / 2));
    r  = 16'(((res % m) + m) % m);
  endtask

  task automatic run(input int w, input logic sub, input logic [15:0] a,
                     input logic [15:0] b, input bit toggle, input string tag);
    logic [15:0] er, o;
    logic ec, eo, co, ov, bz, dn;
    int busycnt;
    bit seen;
    model(wid(w), sub, a, b, er, ec, eo);
    drive(w, 1'b1, sub, a, b);
    @(posedge clk);
    @(negedge clk);
    drive(w, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
    look(w, o, co, ov, bz, dn);
    chk({tag, "_start_busy"}, {31'd0, bz}, 32'd1);
    chk({tag, "_start_out"}, {16'd0, o}, 32'd0);
    chk({tag, "_held_cout"}, {31'd0, co}, {31'd0, prev_cout[w]});
    chk({tag, "_held_ovf"}, {31'd0, ov}, {31'd0, prev_ovf[w]});
    busycnt = 0;
    seen = 0;
    for (int cyc = 0; cyc < 64 && !seen; cyc++) begin
      look(w, o, co, ov, bz, dn);
      chk({tag, "_busy_done_excl"}, {31'd0, bz & dn}, 32'd0);
      if (dn) seen = 1;
      else begin
        if (bz) busycnt++;
        if (toggle) drive(w, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
        @(negedge clk);
      end
    end
    drive(w, 1'b0, 1'b0, 16'd0, 16'd0);
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    chk({tag, "_busy_cycles"}, 32'(busycnt), 32'(ndig(w)));
    chk({tag, "_out"}, {16'd0, o}, {16'd0, er});
    chk({tag, "_cout"}, {31'd0, co}, {31'd0, ec});
    chk({tag, "_ovf"}, {31'd0, ov}, {31'd0, eo});
    prev_cout[w] = ec;
    prev_ovf[w]  = eo;
    repeat (2) @(negedge clk);
    look(w, o, co, ov, bz, dn);
    chk({tag, "_hold_done"}, {31'd0, dn}, 32'd1);
    chk({tag, "_hold_out"}, {16'd0, o}, {16'd0, er});
  endtask

  initial begin
    logic [15:0] o;
    logic co, ov, bz, dn;
    rst = 1'b0;
    for (int w = 0; w < 4; w++) begin
      drive(w, 1'b0, 1'b0, 16'd0, 16'd0);
      prev_cout[w] = 1'b0;
      prev_ovf[w]  = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int w = 0; w < 4; w++) begin
      look(w, o, co, ov, bz, dn);
      chk("reset_state", {o, 13'd0, co, ov, bz | dn}, 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);

    // Directed cases from the plan; expectations come from the model.
    run(0, 1'b0, 16'd3,      16'd5,  0, "add_3_5");
    run(0, 1'b0, 16'd200,    16'd100,0, "add_200_100");
    run(0, 1'b0, 16'd127,    16'd1,  0, "add_127_1");
    run(1, 1'b1, 16'd5,      16'd7,  0, "sub_5_7");
    run(1, 1'b1, 16'h0080,   16'd1,  0, "sub_80_1");
    run(2, 1'b0, 16'hFFFF,   16'd1,  0, "d4_ffff_1");
    run(3, 1'b0, 16'hFFFF,   16'd1,  0, "d16_ffff_1");
    run(0, 1'b1, 16'd9,      16'd200,1, "toggle_en");

    // Reset in the third ADD cycle wipes everything at once.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 16'd77, 16'd99);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 16'd0, 16'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    look(0, o, co, ov, bz, dn);
    chk("midop_reset", {o, 12'd0, co, ov, bz, dn}, 32'd0);
    look(2, o, co, ov, bz, dn);
    chk("midop_reset_other", {o, 12'd0, co, ov, bz, dn}, 32'd0);
    for (int w = 0; w < 4; w++) begin
      prev_cout[w] = 1'b0;
      prev_ovf[w]  = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run(0, 1'b0, 16'd100, 16'd28, 0, "after_reset");

    for (int i = 0; i < 40; i++) begin
      int w;
      w = int'($urandom_range(0, 3));
      run(w, 1'($urandom), 16'($urandom), 16'($urandom), bit'($urandom), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
